mem_wb_elastic_regs: RTL
========================

# mem_wb_elastic_regs

Parametrised successor to the fixed MEM/WB register bank. It replaces the global `stall` with a valid/ready handshake and a two-entry skid buffer, and adds a flush input. It resolves the writeback data mux at capture time, suppresses writes to x0, and counts retired register writes. It sits between the memory stage and the register-file write port.

## Interface
- `DATA_WIDTH`, 64: width of ALU result, memory data and writeback data.
- `REG_ID_WIDTH`, 5: destination register index width.
- `COUNT_WIDTH`, 32: width of the retired-write counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all buffered entries and any same-cycle input.
- `in_valid`  in  1  memory stage presents an instruction.
- `in_ready`  out  1  buffer can accept; equals `!reset && count != 2`.
- `alu_in`  in  DATA_WIDTH  ALU result.
- `mem_data_in`  in  DATA_WIDTH  load data.
- `dest_in`  in  REG_ID_WIDTH  destination register.
- `wb_control_in`  in  2  bit 1 is reg_write, bit 0 is mem_to_reg.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  register file consumes head.
- `wb_data_out`  out  DATA_WIDTH  head writeback data.
- `dest_out`  out  REG_ID_WIDTH  head destination.
- `reg_write_out`  out  1  head write enable.
- `retire_count`  out  COUNT_WIDTH  retired writes since reset.
- `fwd_src_id`  in  REG_ID_WIDTH  forwarding query. Present only with `MEM_WB_FWD_EN`.
- `fwd_hit`  out  1  query matched a buffered write. Present only with `MEM_WB_FWD_EN`.
- `fwd_data`  out  DATA_WIDTH  matched data. Present only with `MEM_WB_FWD_EN`.

## Operation
- **Storage:** two entries, head and skid, plus `count` in {0, 1, 2}. Entries are kept in FIFO order.
- **Captured fields:** each entry holds `wb_data`, `dest` and `rw`.
  - `wb_data = mem_to_reg ? mem_data_in : alu_in`.
  - `rw = reg_write && dest_in != 0`.
- **Transfer conditions:** accept when `in_valid && in_ready`. Consume when `out_valid && out_ready`.
- **count 0 (EMPTY):**
  - accept: write head, go to 1.
- **count 1 (ONE):**
  - accept only: write skid, go to 2.
  - consume only: go to 0.
  - accept and consume: write head with new data, stay at 1.
- **count 2 (FULL):**
  - `in_ready` is 0.
  - consume: skid moves to head, go to 1.
- **Outputs:** `out_valid = (count != 0)`. `wb_data_out`, `dest_out` and `reg_write_out` come from the head entry and are forced to 0 when `count == 0`.
- **Retire counter:** `retire_count` increments on each consume with `reg_write_out == 1`. It wraps modulo 2^COUNT_WIDTH.
- **Flush:**
  - Next state is count 0.
  - A same-cycle accept is dropped. A same-cycle consume still counts toward `retire_count`.
  - Stored data need not be cleared, but the outputs read 0.
- **Reset:**
  - `count = 0`, all entry fields 0, `retire_count = 0`.
  - Reset overrides flush and all transfers.
  - `in_ready = 0` while `reset` is high.

## Timing
- **Latency:** an entry accepted at edge N appears on the outputs after edge N, when the buffer was empty or its predecessor is consumed at N.
- **Throughput:** 1 per cycle with `out_ready` held high. Throughput is never lost to the skid path.
- **`in_ready`:** combinational from `count` and `reset` only; no path from `in_valid` or `out_ready`.
- **`out_valid`:** pure register output. Once asserted, the head is stable until consumed or flushed.
- **Reset values:** `out_valid 0`, `wb_data_out 0`, `dest_out 0`, `reg_write_out 0`, `retire_count 0`, `fwd_hit 0`, `fwd_data 0`. `in_ready` is 0 during reset and 1 on the first cycle after.

## Configuration
- **`MEM_WB_FWD_EN` defined:**
  - `fwd_src_id`, `fwd_hit` and `fwd_data` exist.
  - Forwarding is combinational over valid entries with `rw == 1` and `dest == fwd_src_id`.
  - When both entries match, the skid (younger) entry wins.
  - `fwd_src_id == 0` never hits.
  - On a miss, `fwd_data` is 0.
- **`MEM_WB_FWD_EN` undefined:** those ports and the compare logic are absent. All other behaviour is identical.

## Test plan
- **Reset and single transfer:** reset, then accept alu=0x11, mem=0x22, dest=3, ctrl=2'b11 with `out_ready=1` -> next cycle `out_valid=1`, `wb_data_out=0x22`, `dest_out=3`, `reg_write_out=1`, `retire_count=1` after consume.
- **Backpressure:** hold `out_ready=0` and offer A (alu=0xA) then B (alu=0xB) -> `count` reaches 2 and `in_ready=0`. Release -> outputs 0xA then 0xB on consecutive cycles, no loss or duplication.
- **x0 suppression:** accept dest=0, ctrl=2'b10 -> `out_valid=1`, `reg_write_out=0`, `retire_count` unchanged after consume.
- **Flush:** flush with count=2 and a simultaneous `in_valid` -> next cycle `out_valid=0`, `in_ready=1`, nothing emitted afterwards.
- **Stream:** 100 back-to-back entries with random `out_ready` -> in-order delivery, 100 consumes total, `retire_count` equals the number with reg_write=1 and dest!=0.
- **Forwarding (`MEM_WB_FWD_EN`):** head dest=5 data 0x1, skid dest=5 data 0x2, query 5 -> `fwd_hit=1`, `fwd_data=0x2`. Query 0 -> `fwd_hit=0`.

Source files
------------

// File: rtl/mem_wb_elastic_regs.sv
// mem_wb_elastic_regs: MEM/WB pipeline register with a valid/ready handshake,
// a two-entry skid buffer (head + skid), flush, x0 write suppression and a
// retired-write counter. The writeback mux is resolved at capture time.
// Optional feature: define MEM_WB_FWD_EN to add a combinational forwarding
// port (fwd_src_id / fwd_hit / fwd_data) over the buffered entries.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready depends only on the stored count and reset. out_valid
// depends only on the stored count. Once out_valid is high, the head stays
// stable until it is consumed or flushed.
module mem_wb_elastic_regs #(
  parameter int DATA_WIDTH   = 64,
  parameter int REG_ID_WIDTH = 5,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   alu_in,
  input  logic [DATA_WIDTH-1:0]   mem_data_in,
  input  logic [REG_ID_WIDTH-1:0] dest_in,
  input  logic [1:0]              wb_control_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   wb_data_out,
  output logic [REG_ID_WIDTH-1:0] dest_out,
  output logic                    reg_write_out,
`ifdef MEM_WB_FWD_EN
  input  logic [REG_ID_WIDTH-1:0] fwd_src_id,
  output logic                    fwd_hit,
  output logic [DATA_WIDTH-1:0]   fwd_data,
`endif
  output logic [COUNT_WIDTH-1:0]  retire_count
);

  // The occupancy count is the FSM state: EMPTY (0), ONE (1), FULL (2).
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   head_data_q, head_data_d;
  logic [REG_ID_WIDTH-1:0] head_dest_q, head_dest_d;
  logic                    head_rw_q, head_rw_d;
  logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [REG_ID_WIDTH-1:0] skid_dest_q, skid_dest_d;
  logic                    skid_rw_q, skid_rw_d;
  logic [COUNT_WIDTH-1:0]  retire_q, retire_d;

  logic                    head_valid;
  logic                    accept;
  logic                    consume;
  logic [DATA_WIDTH-1:0]   cap_data;
  logic                    cap_rw;

  assign head_valid = (state_q != S_EMPTY);
  assign in_ready   = !reset && (state_q != S_FULL);
  assign accept     = in_valid && in_ready;
  assign consume    = head_valid && out_ready;

  // Resolve the writeback mux and x0 suppression on the way in.
  always_comb begin
    cap_data = wb_control_in[0] ? mem_data_in : alu_in;
    cap_rw   = wb_control_in[1] && (dest_in != '0);
  end

  // State register: occupancy, both entries and the retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      head_data_q <= '0;
      head_dest_q <= '0;
      head_rw_q   <= 1'b0;
      skid_data_q <= '0;
      skid_dest_q <= '0;
      skid_rw_q   <= 1'b0;
      retire_q    <= '0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_dest_q <= head_dest_d;
      head_rw_q   <= head_rw_d;
      skid_data_q <= skid_data_d;
      skid_dest_q <= skid_dest_d;
      skid_rw_q   <= skid_rw_d;
      retire_q    <= retire_d;
    end
  end

  // Next-state logic: FIFO ordering of head/skid; flush empties the buffer
  // and drops a same-cycle accept (entry data may linger but is masked).
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_dest_d = head_dest_q;
    head_rw_d   = head_rw_q;
    skid_data_d = skid_data_q;
    skid_dest_d = skid_dest_q;
    skid_rw_d   = skid_rw_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          head_data_d = cap_data;
          head_dest_d = dest_in;
          head_rw_d   = cap_rw;
          state_d     = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && consume) begin
          head_data_d = cap_data;
          head_dest_d = dest_in;
          head_rw_d   = cap_rw;
        end else if (accept) begin
          skid_data_d = cap_data;
          skid_dest_d = dest_in;
          skid_rw_d   = cap_rw;
          state_d     = S_FULL;
        end else if (consume) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (consume) begin
          head_data_d = skid_data_q;
          head_dest_d = skid_dest_q;
          head_rw_d   = skid_rw_q;
          state_d     = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) begin
      state_d = S_EMPTY;
    end
  end

  // Retire counter: a consumed head with a write enable counts, even on flush.
  always_comb begin
    retire_d = retire_q;
    if (consume && head_rw_q) begin
      retire_d = retire_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Output logic: head fields, forced to zero while empty.
  always_comb begin
    out_valid     = head_valid;
    wb_data_out   = head_valid ? head_data_q : '0;
    dest_out      = head_valid ? head_dest_q : '0;
    reg_write_out = head_valid && head_rw_q;
    retire_count  = retire_q;
  end

`ifdef MEM_WB_FWD_EN
  // Forwarding lookup: the younger skid entry takes priority over the head.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_src_id != '0) begin
      if ((state_q == S_FULL) && skid_rw_q && (skid_dest_q == fwd_src_id)) begin
        fwd_hit  = 1'b1;
        fwd_data = skid_data_q;
      end else if (head_valid && head_rw_q && (head_dest_q == fwd_src_id)) begin
        fwd_hit  = 1'b1;
        fwd_data = head_data_q;
      end
    end
  end
`endif

endmodule
